led_pattern_gen: RTL and testbench

- Parametrised LED driver for the DE2 board LEDG bank, clocked from CLOCK_50.
- Generalises the original 2-bit free-running toggler with:
  - a programmable prescaler
  - N_LEDS outputs
  - four selectable display modes (blink, chase, bounce, binary count)
  - enable/freeze control
- Sits between board switch/key logic (mode, enable, divisor) and the LEDG pins.

---
 rtl/led_pkg.sv | 33 +++
 rtl/led_prescaler.sv | 48 ++++
 rtl/led_pattern_gen.sv | 97 +++++++++
 tb/tb_led_pattern_gen.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// Shared mode encoding, bounce direction and per-mode initial LED patterns for led_pattern_gen.
package led_pkg;

   typedef enum logic [1:0] {
      MODE_BLINK  = 2'b00,
      MODE_CHASE  = 2'b01,
      MODE_BOUNCE = 2'b10,
      MODE_COUNT  = 2'b11
   } mode_e;

   typedef enum logic {
      DirLeft,
      DirRight
   } dir_e;

   // Returns the pattern for a freshly entered mode, masked to the low n LEDs.
   function automatic logic [31:0] init_pattern(input mode_e m, input int unsigned n);
      logic [31:0] mask;
      logic [31:0] pat;
      mask = '0;
      for (int unsigned i = 0; i < 32; i++) begin
         if (i < n) mask[i] = 1'b1;
      end
      case (m)
         MODE_BLINK:  pat = 32'h5555_5555;
         MODE_CHASE:  pat = 32'h0000_0001;
         MODE_BOUNCE: pat = 32'h0000_0001;
         default:     pat = 32'h0000_0000;
      endcase
      return pat & mask;
   endfunction

endpackage

// File: rtl/led_prescaler.sv
// Programmable prescaler: divisor register plus wrap counter emitting a one-cycle step strobe.
module led_prescaler
   import led_pkg::*;
#(
   parameter int unsigned DIV_WIDTH   = 26,
   parameter int unsigned DEFAULT_DIV = 25000000
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 enable_i,
   input  logic                 clear_i,
   input  logic                 load_i,
   input  logic [DIV_WIDTH-1:0] load_value_i,
   output logic                 step_o
);

   logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
   logic [DIV_WIDTH-1:0] div_q, div_d;
   logic [DIV_WIDTH-1:0] div_eff;
   logic                 at_wrap;

   // A zero divisor behaves as one so the counter always has a reachable terminal value.
   assign div_eff = (div_q == '0) ? DIV_WIDTH'(1) : div_q;
   assign at_wrap = (cnt_q == (div_eff - DIV_WIDTH'(1)));
   assign step_o  = enable_i & ~clear_i & at_wrap;

   always_comb begin
      cnt_d = cnt_q;
      div_d = div_q;
      if (load_i) div_d = load_value_i;
      if (clear_i) begin
         cnt_d = '0;
      end else if (enable_i) begin
         cnt_d = at_wrap ? '0 : cnt_q + DIV_WIDTH'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
         div_q <= DIV_WIDTH'(DEFAULT_DIV);
      end else begin
         cnt_q <= cnt_d;
         div_q <= div_d;
      end
   end

endmodule

// File: rtl/led_pattern_gen.sv
// LEDG pattern generator: blink, chase, bounce and binary count, stepped by led_prescaler.
module led_pattern_gen
   import led_pkg::*;
#(
   parameter int unsigned N_LEDS      = 8,
   parameter int unsigned DIV_WIDTH   = 26,
   parameter int unsigned DEFAULT_DIV = 25000000
) (
   input  logic                 CLOCK_50,
   input  logic                 RST_N,
   input  logic                 enable,
   input  logic [1:0]           mode,
   input  logic                 div_load,
   input  logic [DIV_WIDTH-1:0] div_value,
   output logic [N_LEDS-1:0]    LEDG,
   output logic                 tick
);

   localparam logic [31:0] RstPattern = init_pattern(MODE_BLINK, N_LEDS);

   mode_e             mode_q, mode_d, mode_new;
   dir_e              dir_q, dir_d;
   logic [N_LEDS-1:0] led_d;
   logic              tick_d;
   logic              mode_chg;
   logic              step;
   logic [31:0]       init_new;

   assign mode_new = mode_e'(mode);
   assign mode_chg = (mode_new != mode_q);
   assign init_new = init_pattern(mode_new, N_LEDS);

   led_prescaler #(
      .DIV_WIDTH   (DIV_WIDTH),
      .DEFAULT_DIV (DEFAULT_DIV)
   ) u_prescaler (
      .clk_i        (CLOCK_50),
      .rst_ni       (RST_N),
      .enable_i     (enable),
      .clear_i      (mode_chg | div_load),
      .load_i       (div_load),
      .load_value_i (div_value),
      .step_o       (step)
   );

   always_comb begin
      mode_d = mode_q;
      dir_d  = dir_q;
      led_d  = LEDG;
      tick_d = 1'b0;
      if (mode_chg) begin
         mode_d = mode_new;
         dir_d  = DirLeft;
         led_d  = init_new[N_LEDS-1:0];
      end else if (step) begin
         tick_d = 1'b1;
         case (mode_q)
            MODE_BLINK: led_d = ~LEDG;
            MODE_CHASE: led_d = {LEDG[N_LEDS-2:0], LEDG[N_LEDS-1]};
            MODE_BOUNCE: begin
               // Reflect off the end LEDs so neither end is lit for two steps.
               if (dir_q == DirLeft) begin
                  if (LEDG[N_LEDS-1]) begin
                     led_d = N_LEDS'(1) << (N_LEDS - 2);
                     dir_d = DirRight;
                  end else begin
                     led_d = LEDG << 1;
                  end
               end else begin
                  if (LEDG[0]) begin
                     led_d = N_LEDS'(2);
                     dir_d = DirLeft;
                  end else begin
                     led_d = LEDG >> 1;
                  end
               end
            end
            default: led_d = LEDG + N_LEDS'(1);
         endcase
      end
   end

   always_ff @(posedge CLOCK_50 or negedge RST_N) begin
      if (!RST_N) begin
         mode_q <= MODE_BLINK;
         dir_q  <= DirLeft;
         LEDG   <= RstPattern[N_LEDS-1:0];
         tick   <= 1'b0;
      end else begin
         mode_q <= mode_d;
         dir_q  <= dir_d;
         LEDG   <= led_d;
         tick   <= tick_d;
      end
   end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Scoreboard bench: stimulus schedules cycle-stamped LEDG/tick expectations, monitor checks them.
module tb_led_pattern_gen;

   localparam int unsigned NL = 4;
   localparam int unsigned DW = 8;

   logic          CLOCK_50 = 1'b0;
   logic          RST_N    = 1'b1;
   logic          enable   = 1'b1;
   logic [1:0]    mode     = 2'b00;
   logic          div_load = 1'b0;
   logic [DW-1:0] div_value = '0;
   logic [NL-1:0] LEDG;
   logic          tick;

   led_pattern_gen #(
      .N_LEDS      (NL),
      .DIV_WIDTH   (DW),
      .DEFAULT_DIV (4)
   ) dut (
      .CLOCK_50  (CLOCK_50),
      .RST_N     (RST_N),
      .enable    (enable),
      .mode      (mode),
      .div_load  (div_load),
      .div_value (div_value),
      .LEDG      (LEDG),
      .tick      (tick)
   );

   always #5 CLOCK_50 = ~CLOCK_50;

   typedef struct {
      int         cyc;
      logic [3:0] led;
      logic       tk;
      string      name;
   } exp_t;

   exp_t       sb[$];
   logic [3:0] seq[$];
   int         cyc = 0;
   int         n_run = 0;
   int         n_fail = 0;
   bit         done = 1'b0;

   always @(posedge CLOCK_50) cyc <= cyc + 1;

   task automatic exp1(input int c, input logic [3:0] l, input logic t, input string nm);
      exp_t e;
      e.cyc = c; e.led = l; e.tk = t; e.name = nm;
      sb.push_back(e);
   endtask

   // Expect init at base, then seq[i] with a tick every `period` cycles, holding in between.
   task automatic sched(input int base, input int period, input logic [3:0] init,
                        input string nm);
      int last;
      last = period * seq.size();
      for (int k = 0; k <= last; k++) begin
         if (k / period == 0) exp1(base + k, init, 1'b0, nm);
         else exp1(base + k, seq[k / period - 1], (k % period == 0) && (k != 0), nm);
      end
   endtask

   task automatic wait_cyc(input int n);
      while (cyc < n) begin
         @(posedge CLOCK_50);
         #1;
      end
   endtask

   always @(negedge CLOCK_50) begin
      exp_t e;
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
         e = sb.pop_front();
         n_run++; n_fail++;
         $display("FAIL %s: expectation for cycle %0d never checked (now %0d)", e.name, e.cyc,
                  cyc);
      end
      if (sb.size() > 0 && sb[0].cyc == cyc) begin
         e = sb.pop_front();
         n_run++;
         if (LEDG !== e.led || tick !== e.tk) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: LEDG=%b tick=%b, expected LEDG=%b tick=%b", e.name, cyc,
                     LEDG, tick, e.led, e.tk);
         end
      end
      if (done) begin
         n_run++;
         if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL leftover: %0d expectations pending, expected 0", sb.size());
         end
         $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
         $finish;
      end
      if (cyc > 2000) begin
         $display("FAIL timeout: cycle %0d exceeded budget 2000", cyc);
         $fatal(1, "timeout");
      end
   end

   initial begin
      int b, l, m, d, e, c;
      #1 RST_N = 1'b0;
      @(posedge CLOCK_50); #1;
      exp1(cyc, 4'b0101, 1'b0, "reset");
      @(posedge CLOCK_50); #1;
      RST_N = 1'b1;
      // BLINK at default divisor 4.
      b = cyc;
      seq = '{4'b1010, 4'b0101};
      sched(b, 4, 4'b0101, "blink");
      wait_cyc(b + 8);
      // CHASE.
      b = cyc; mode = 2'b01;
      seq = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
      sched(b + 1, 4, 4'b0001, "chase");
      wait_cyc(b + 17);
      // COUNT through wrap.
      b = cyc; mode = 2'b11;
      seq = '{4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0101, 4'b0110, 4'b0111, 4'b1000,
              4'b1001, 4'b1010, 4'b1011, 4'b1100, 4'b1101, 4'b1110, 4'b1111, 4'b0000};
      sched(b + 1, 4, 4'b0000, "count");
      wait_cyc(b + 65);
      // BOUNCE with reflections at both ends.
      b = cyc; mode = 2'b10;
      seq = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010};
      sched(b + 1, 4, 4'b0001, "bounce");
      wait_cyc(b + 29);
      // BLINK, then divisor 0 (step every cycle), then divisor 2.
      b = cyc; mode = 2'b00;
      seq = {};
      sched(b + 1, 4, 4'b0101, "blink_re");
      wait_cyc(b + 1);
      div_load = 1'b1; div_value = 8'd0;
      seq = '{4'b1010, 4'b0101, 4'b1010, 4'b0101, 4'b1010, 4'b0101};
      sched(b + 2, 1, 4'b0101, "div0");
      wait_cyc(b + 2);
      div_load = 1'b0;
      wait_cyc(b + 8);
      l = cyc; div_load = 1'b1; div_value = 8'd2;
      seq = '{4'b1010, 4'b0101, 4'b1010};
      sched(l + 1, 2, 4'b0101, "div2");
      wait_cyc(l + 1);
      div_load = 1'b0;
      wait_cyc(l + 7);
      // COUNT with divisor 4 loaded in the same cycle as the mode change.
      m = cyc; mode = 2'b11; div_load = 1'b1; div_value = 8'd4;
      seq = '{4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0101, 4'b0110};
      sched(m + 1, 4, 4'b0000, "count_load");
      exp1(m + 26, 4'b0110, 1'b0, "count_mid");
      exp1(m + 27, 4'b0110, 1'b0, "count_mid");
      wait_cyc(m + 1);
      div_load = 1'b0;
      wait_cyc(m + 27);
      // Freeze with prescaler at 2; resume needs two more edges.
      d = cyc; enable = 1'b0;
      for (int k = 1; k <= 11; k++) exp1(d + k, 4'b0110, 1'b0, "freeze");
      exp1(d + 12, 4'b0111, 1'b1, "resume");
      wait_cyc(d + 10);
      enable = 1'b1;
      wait_cyc(d + 12);
      enable = 1'b0; mode = 2'b01;
      for (int k = 13; k <= 16; k++) exp1(d + k, 4'b0001, 1'b0, "mode_while_off");
      wait_cyc(d + 16);
      // BOUNCE moving right, then asynchronous reset between edges.
      e = cyc; mode = 2'b10; enable = 1'b1;
      seq = '{4'b0010, 4'b0100, 4'b1000, 4'b0100};
      sched(e + 1, 4, 4'b0001, "bounce_pre");
      wait_cyc(e + 18);
      RST_N = 1'b0; mode = 2'b00;
      exp1(e + 18, 4'b0101, 1'b0, "async_rst");
      wait_cyc(e + 19);
      RST_N = 1'b1;
      c = cyc;
      seq = '{4'b1010, 4'b0101};
      sched(c, 4, 4'b0101, "post_rst");
      wait_cyc(c + 8);
      done = 1'b1;
   end

endmodule
